// File: rtl/issue_queue.sv
// Issue queue: a circular buffer of {inst, pc} entries. Fetch pushes up to
// FETCH_WIDTH entries per cycle. Each cycle an in-order group of up to
// ISSUE_WIDTH head entries is formed, and that group is cut at the first
// RAW, WAW, second-memory-op or post-control hazard.

// Per-slot RV32 decode of the fields used by the group hazard checks.
module iq_decode (
  input  logic [31:0] i_inst,
  output logic        o_wr,
  output logic        o_use1,
  output logic        o_use2,
  output logic        o_mem,
  output logic        o_ctrl,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2
);
  logic [6:0] w_op;
  logic       w_unused;

  assign w_op     = i_inst[6:0];
  assign o_rd     = i_inst[11:7];
  assign o_rs1    = i_inst[19:15];
  assign o_rs2    = i_inst[24:20];
  assign w_unused = ^{i_inst[31:25], i_inst[14:12]};

  // Opcode-class flags.
  always_comb begin
    o_wr   = (w_op == 7'b0000011 || w_op == 7'b0010011 || w_op == 7'b0110011 ||
              w_op == 7'b0110111 || w_op == 7'b0010111 || w_op == 7'b1101111 ||
              w_op == 7'b1100111) && (o_rd != 5'd0);
    o_use1 = !(w_op == 7'b0110111 || w_op == 7'b0010111 || w_op == 7'b1101111);
    o_use2 = (w_op == 7'b0110011 || w_op == 7'b0100011 || w_op == 7'b1100011);
    o_mem  = (w_op == 7'b0000011 || w_op == 7'b0100011);
    o_ctrl = (w_op == 7'b1100011 || w_op == 7'b1101111 || w_op == 7'b1100111);
  end
endmodule

module issue_queue #(
  parameter int FETCH_WIDTH = 2,
  parameter int ISSUE_WIDTH = 2,
  parameter int DEPTH       = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [$clog2(FETCH_WIDTH+1)-1:0] in_count,
  input  logic [32*FETCH_WIDTH-1:0]        in_inst,
  input  logic [31:0]                      in_pc,
  output logic                             in_ready,
  output logic [ISSUE_WIDTH-1:0]           out_valid,
  output logic [32*ISSUE_WIDTH-1:0]        out_inst,
  output logic [32*ISSUE_WIDTH-1:0]        out_pc,
  input  logic                             out_ready,
  input  logic                             flush,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IN_W  = $clog2(FETCH_WIDTH+1);

  logic [31:0]      r_inst [DEPTH];
  logic [31:0]      r_pc   [DEPTH];
  logic [PTR_W-1:0] r_head, r_tail;
  logic [CNT_W-1:0] r_count;

  logic [ISSUE_WIDTH-1:0][31:0] w_hd_inst, w_hd_pc;
  logic [ISSUE_WIDTH-1:0]       w_wr, w_use1, w_use2, w_mem, w_ctrl, w_valid;
  logic [ISSUE_WIDTH-1:0][4:0]  w_rd, w_rs1, w_rs2;
  logic [CNT_W-1:0]             w_push_n, w_pop_n;

  // Credit is granted from registered occupancy only, so pops never feed in_ready.
  assign in_ready  = (r_count <= CNT_W'(DEPTH - FETCH_WIDTH));
  assign count     = r_count;
  assign out_valid = w_valid;
  assign out_inst  = w_hd_inst;
  assign out_pc    = w_hd_pc;

  // Head window: read and decode the oldest ISSUE_WIDTH entries.
  for (genvar j = 0; j < ISSUE_WIDTH; j++) begin : g_slot
    assign w_hd_inst[j] = r_inst[r_head + PTR_W'(j)];
    assign w_hd_pc[j]   = r_pc[r_head + PTR_W'(j)];
    iq_decode u_dec (
      .i_inst (w_hd_inst[j]),
      .o_wr   (w_wr[j]),
      .o_use1 (w_use1[j]),
      .o_use2 (w_use2[j]),
      .o_mem  (w_mem[j]),
      .o_ctrl (w_ctrl[j]),
      .o_rd   (w_rd[j]),
      .o_rs1  (w_rs1[j]),
      .o_rs2  (w_rs2[j])
    );
  end

  // Group formation. The mask is contiguous, so every slot before j is already valid.
  always_comb begin
    logic ok;
    w_valid    = '0;
    w_valid[0] = (r_count != '0) && !flush;
    for (int j = 1; j < ISSUE_WIDTH; j++) begin
      ok = w_valid[j-1] && (r_count > CNT_W'(j));
      for (int i = 0; i < j; i++) begin
        if (w_wr[i] && ((w_use1[j] && w_rd[i] == w_rs1[j]) ||
                        (w_use2[j] && w_rd[i] == w_rs2[j]))) ok = 1'b0;
        if (w_wr[i] && w_wr[j] && w_rd[i] == w_rd[j])        ok = 1'b0;
        if (w_mem[i] && w_mem[j])                            ok = 1'b0;
        if (w_ctrl[i])                                       ok = 1'b0;
      end
      w_valid[j] = ok;
    end
  end

  // Push/pop amounts. Flush has already zeroed w_valid, and it blocks the push.
  always_comb begin
    w_pop_n  = '0;
    w_push_n = '0;
    if (out_ready) begin
      for (int j = 0; j < ISSUE_WIDTH; j++) w_pop_n = w_pop_n + CNT_W'(w_valid[j]);
    end
    if (in_ready && !flush) begin
      if (in_count > IN_W'(FETCH_WIDTH)) w_push_n = CNT_W'(FETCH_WIDTH);
      else                               w_push_n = CNT_W'(in_count);
    end
  end

  // Storage write. The payload needs no reset because occupancy gates visibility.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (CNT_W'(k) < w_push_n) begin
          r_inst[r_tail + PTR_W'(k)] <= in_inst[32*k +: 32];
          r_pc[r_tail + PTR_W'(k)]   <= in_pc + 32'(4*k);
        end
      end
    end
  end

  // Pointer and occupancy update. Flush empties the queue; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(w_pop_n);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + w_push_n - w_pop_n;
    end
  end
endmodule

// File: doc/issue_queue.md
ISSUE_QUEUE -- requirements
Module: issue_queue

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2: maximum instructions pushed per cycle.
REQ-002 SHALL have parameter ISSUE_WIDTH, default 2: maximum instructions issued per cycle.
REQ-003 SHALL have parameter DEPTH, default 8: entry count; power of two, DEPTH >= FETCH_WIDTH and DEPTH >= ISSUE_WIDTH.
REQ-004 SHALL have port clock  input  1  the one clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port in_count  input  $clog2(FETCH_WIDTH+1)  number of instructions offered, taken from slot 0 upward.
REQ-007 SHALL have port in_inst  input  32*FETCH_WIDTH  offered instructions; slot k is bits [32k+31:32k].
REQ-008 SHALL have port in_pc  input  32  PC of slot 0; slot k has PC in_pc+4k.
REQ-009 SHALL have port in_ready  output  1  queue can accept FETCH_WIDTH entries this cycle.
REQ-010 SHALL have port out_valid  output  ISSUE_WIDTH  contiguous mask from bit 0 of the issuable head entries.
REQ-011 SHALL have port out_inst  output  32*ISSUE_WIDTH  head instructions, oldest in slot 0.
REQ-012 SHALL have port out_pc  output  32*ISSUE_WIDTH  PCs of the head instructions.
REQ-013 SHALL have port out_ready  input  1  downstream takes every slot flagged in out_valid.
REQ-014 SHALL have port flush  input  1  branch/jump redirect; discard all contents.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL store entries as {inst, pc} in a circular buffer with head and tail pointers wrapping modulo DEPTH.
REQ-017 SHALL drive in_ready = (DEPTH - count) >= FETCH_WIDTH from registered count only; same-cycle pops grant no credit.
REQ-018 SHALL push exactly in_count entries when in_ready=1 and flush=0; it SHALL drop the whole offer and change no state when in_ready=0.
REQ-019 SHALL decode per entry: writes_rd if opcode in {0000011,0010011,0110011,0110111,0010111,1101111,1100111} and rd!=0.
REQ-020 SHALL decode per entry: uses_rs1 unless opcode in {0110111,0010111,1101111}; uses_rs2 only for opcode in {0110011,0100011,1100011}.
REQ-021 SHALL decode per entry: mem_op for opcode 0000011 or 0100011; ctrl_op for opcode 1100011, 1101111 or 1100111.
REQ-022 SHALL always make slot 0 valid when count >= 1.
REQ-023 SHALL make slot j>0 valid only if slot j-1 is valid and entry j exists.
REQ-024 SHALL make slot j>0 valid only if no valid earlier slot i in the group has writes_rd with rd equal to a used rs of j (RAW).
REQ-025 SHALL make slot j>0 valid only if no valid earlier slot has the same written rd (WAW).
REQ-026 SHALL make slot j>0 valid only if j is not the second mem_op in the group.
REQ-027 SHALL make slot j>0 valid only if no earlier slot is ctrl_op; a ctrl_op ends the group.
REQ-028 SHALL compute out_valid/out_inst/out_pc combinationally from registered storage; data in slots not set in out_valid is don't-care.
REQ-029 SHALL pop popcount(out_valid) entries when out_ready=1, flush=0 and out_valid!=0.
REQ-030 SHALL apply simultaneous push and pop in one cycle: count_next = count + pushed - popped.
REQ-031 SHALL give flush priority: out_valid forced to 0 in the flush cycle, no push, no pop, count=0 and head=tail next cycle.
REQ-032 SHALL hold an entry stable at the head until popped; no reordering.

Reset
REQ-033 SHALL, with reset=1 at a rising edge, set count=0, head=tail=0, leaving out_valid=0 and in_ready=1 after the edge, discarding any push/pop/flush that cycle, including mid-operation.

Verification
REQ-034 SHALL pass: push 0x00100093, 0x00200113 at in_pc=0x24 -> next cycle out_valid=2'b11, out_pc=0x24/0x28; out_ready=1 -> count=0.
REQ-035 SHALL pass: push 0x00100093 then 0x001081B3 (RAW x1) -> out_valid=2'b01; after pop, out_valid=2'b01 with out_pc of the add.
REQ-036 SHALL pass: push lw 0x00002283 then 0x00402303 -> out_valid=2'b01 twice; also beq 0x00000063 then addi -> 2'b01.
REQ-037 SHALL pass: 4 pushes of 2 with out_ready=0 -> count=8, in_ready=0, 5th push ignored; one pop of 2 -> in_ready=1 next cycle, pointers wrap correctly.
REQ-038 SHALL pass: count=6, flush=1 with concurrent push and out_ready=1 -> out_valid=0 that cycle; next cycle count=0; pushed instructions never appear.
REQ-039 SHALL pass: reset asserted with count=5 -> next cycle count=0, out_valid=0, in_ready=1.
